// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types, constants and helpers for the load/store-multiple sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         ADDR_STEP = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit16.sv
// Combinational 16->4 priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_bit16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = |vec_i;
    for (int i = 15; i >= 0; i--) begin
      idx_o = vec_i[i] ? 4'(i) : idx_o;
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle LDM/STM engine driving the register file and data memory.
// Optional feature: define LDM_STM_ABORT_EN to add mem_abort/abort handling.
module ldm_stm_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = ldm_stm_sequencer_pkg::ADDR_STEP
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre,
  input  logic              up,
  input  logic              wback,
  input  logic [3:0]        rn,
  input  logic [15:0]       reg_list,
  input  logic [DATA_W-1:0] base_val,
  output logic [3:0]        rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [3:0]        rf_wa,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wd,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef LDM_STM_ABORT_EN
  input  logic              mem_abort,
  output logic              abort,
`endif
  output logic              busy,
  output logic              done
);

  import ldm_stm_sequencer_pkg::*;

  localparam logic [DATA_W-1:0] STEP = DATA_W'(ADDR_STEP);

  state_e            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] nbase_q, nbase_d;
  logic [3:0]        rn_q, rn_d;
  logic              is_load_q, is_load_d;
  logic              wb_en_q, wb_en_d;
`ifdef LDM_STM_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  logic [3:0]        cur_s;
  logic              cur_vld_s;
  logic [DATA_W-1:0] span_s;
  logic [DATA_W-1:0] start_addr_s;

  lowest_set_bit16 u_lsb (
    .vec_i   (list_q),
    .idx_o   (cur_s),
    .valid_o (cur_vld_s)
  );

  assign span_s = DATA_W'(popcount16(reg_list)) * STEP;

  // Start address of the lowest-indexed register for each P/U addressing mode.
  always_comb begin
    case ({pre, up})
      2'b01:   start_addr_s = base_val;
      2'b11:   start_addr_s = base_val + STEP;
      2'b00:   start_addr_s = base_val - span_s + STEP;
      2'b10:   start_addr_s = base_val - span_s;
      default: start_addr_s = base_val;
    endcase
  end

  // State and transfer-context registers.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q   <= IDLE;
      list_q    <= 16'h0000;
      addr_q    <= '0;
      nbase_q   <= '0;
      rn_q      <= 4'd0;
      is_load_q <= 1'b0;
      wb_en_q   <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      nbase_q   <= nbase_d;
      rn_q      <= rn_d;
      is_load_q <= is_load_d;
      wb_en_q   <= wb_en_d;
`ifdef LDM_STM_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  // Next-state and datapath outputs; every output is 0 unless its state drives it.
  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    addr_d    = addr_q;
    nbase_d   = nbase_q;
    rn_d      = rn_q;
    is_load_d = is_load_q;
    wb_en_d   = wb_en_q;
`ifdef LDM_STM_ABORT_EN
    aborted_d = aborted_q;
`endif
    rf_ra     = 4'd0;
    rf_wa     = 4'd0;
    rf_we     = 1'b0;
    rf_wd     = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          list_d    = reg_list;
          addr_d    = start_addr_s;
          nbase_d   = up ? (base_val + span_s) : (base_val - span_s);
          rn_d      = rn;
          is_load_d = is_load;
          // A loaded base or a PC base must never be overwritten by writeback.
          wb_en_d   = wback && !(is_load && reg_list[rn]) && (rn != REG_PC);
`ifdef LDM_STM_ABORT_EN
          aborted_d = 1'b0;
`endif
          state_d   = (reg_list == 16'h0000) ? DONE : XFER;
        end else begin
          state_d   = IDLE;
        end
      end

      XFER: begin
        mem_req   = cur_vld_s;
        mem_we    = !is_load_q;
        mem_addr  = addr_q;
        rf_ra     = cur_s;
        mem_wdata = rf_rd;
`ifdef LDM_STM_ABORT_EN
        if (mem_abort) begin
          aborted_d = 1'b1;
          list_d    = 16'h0000;
          state_d   = DONE;
        end else
`endif
        if (mem_ack) begin
          if (is_load_q && (cur_s == REG_PC)) begin
            pc_we = 1'b1;
            pc_wd = mem_rdata;
          end else if (is_load_q) begin
            rf_we = 1'b1;
            rf_wa = cur_s;
            rf_wd = mem_rdata;
          end else begin
            rf_we = 1'b0;
          end
          list_d  = list_q & ~(16'h0001 << cur_s);
          addr_d  = addr_q + STEP;
          state_d = (list_d == 16'h0000) ? WB : XFER;
        end else begin
          state_d = XFER;
        end
      end

      WB: begin
        if (wb_en_q) begin
          rf_we = 1'b1;
          rf_wa = rn_q;
          rf_wd = nbase_q;
        end else begin
          rf_we = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
`ifdef LDM_STM_ABORT_EN
  assign abort = (state_q == DONE) && aborted_q;
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a transaction-level model predicts memory,
// register-file, PC and completion events; a monitor compares them as the DUT emits them.
module tb_ldm_stm_sequencer;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start     = 1'b0;
  logic        is_load   = 1'b0;
  logic        pre       = 1'b0;
  logic        up        = 1'b0;
  logic        wback     = 1'b0;
  logic [3:0]  rn        = 4'd0;
  logic [15:0] reg_list  = 16'h0;
  logic [31:0] base_val  = 32'h0;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, pc_wd, mem_addr, mem_wdata;
  logic        rf_we, pc_we, mem_req, mem_we, busy, done;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;
  logic        mem_abort = 1'b0;
  logic        abort_o;

  logic [31:0] rf [16];
  assign rf_rd = rf[rf_ra];

  ldm_stm_sequencer #(.DATA_W(32), .ADDR_STEP(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .is_load(is_load),
    .pre(pre), .up(up), .wback(wback), .rn(rn), .reg_list(reg_list), .base_val(base_val),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
    .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef LDM_STM_ABORT_EN
    .mem_abort(mem_abort), .abort(abort_o),
`endif
    .busy(busy), .done(done)
  );
`ifndef LDM_STM_ABORT_EN
  assign abort_o = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] idx; logic [31:0] wdata; } mem_ev_t;
  typedef struct { logic [3:0] wa; logic [31:0] wd; } rf_ev_t;
  typedef struct { int cyc; logic ab; } done_ev_t;

  mem_ev_t     exp_mem_q[$];
  rf_ev_t      exp_rf_q[$];
  logic [31:0] exp_pc_q[$];
  done_ev_t    exp_done_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int ack_dly = 0, abort_at = -1;
  bit in_reset = 1'b1;
  logic [31:0] seed_g = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed_g;
  endfunction

  // Reference model: transfer order, addresses, data, writeback and completion time of one op.
  task automatic model(input logic ld, input logic p, input logic u, input logic w,
                       input logic [3:0] r, input logic [15:0] lst, input logic [31:0] base,
                       input int d, input int ab, input int c0);
    int regs[$];
    int n, words, lat;
    bit aborted;
    logic [31:0] a0, nb;
    mem_ev_t m;
    rf_ev_t  e;
    done_ev_t dn;
    for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
    n = regs.size();
    if (u) a0 = p ? base + 32'd4 : base;
    else   a0 = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    nb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    aborted = (ab >= 0) && (ab < n);
    words = aborted ? ab + 1 : n;
    for (int k = 0; k < words; k++) begin
      m.addr = a0 + 32'(4 * k); m.we = !ld; m.idx = 4'(regs[k]); m.wdata = rf[regs[k]];
      exp_mem_q.push_back(m);
      if (ld && !(aborted && k == ab)) begin
        if (regs[k] == 15) exp_pc_q.push_back(memval(m.addr));
        else begin e.wa = 4'(regs[k]); e.wd = memval(m.addr); exp_rf_q.push_back(e); end
      end
    end
    if (n > 0 && !aborted && w && r != 4'd15 && !(ld && lst[r])) begin
      e.wa = r; e.wd = nb; exp_rf_q.push_back(e);
    end
    if (n == 0)       lat = 1;
    else if (aborted) lat = words * (d + 1) + 1;
    else              lat = n * (d + 1) + 2;
    dn.cyc = c0 + lat; dn.ab = aborted;
    exp_done_q.push_back(dn);
  endtask

  task automatic run_op(input logic ld, input logic p, input logic u, input logic w,
                        input logic [3:0] r, input logic [15:0] lst, input logic [31:0] base,
                        input int d, input int ab, input bit spur);
    @(negedge sys_clk);
    ack_dly = d; abort_at = ab;
    rf[r] = base;
    model(ld, p, u, w, r, lst, base, d, ab, cyc);
    is_load = ld; pre = p; up = u; wback = w; rn = r; reg_list = lst; base_val = base;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 400 && busy; k++) begin
      if (spur) begin
        start = 1'($urandom_range(1)); reg_list = 16'($urandom); is_load = 1'($urandom);
        rn = 4'($urandom); base_val = $urandom;
      end
      @(negedge sys_clk);
    end
    start = 1'b0;
    chk("busy_released", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, "_pc_we"}, {31'd0, pc_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rf_ra"}, {28'd0, rf_ra}, 32'd0);
    chk({tag, "_abort"}, {31'd0, abort_o}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  // Memory responder: ack after ack_dly wait cycles, optional abort, stray acks when idle.
  initial begin
    int wait_cnt, word_idx;
    wait_cnt = 0; word_idx = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      mem_ack = 1'b0; mem_abort = 1'b0; mem_rdata = 32'h0;
      if (mem_req) begin
        if (wait_cnt >= ack_dly) begin
          wait_cnt = 0;
          if (word_idx == abort_at) mem_abort = 1'b1;
          else begin mem_ack = 1'b1; mem_rdata = memval(mem_addr); end
          word_idx++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0; word_idx = 0;
        if ($urandom_range(3) == 0) begin mem_ack = 1'b1; mem_rdata = $urandom; end
      end
    end
  end

  // Monitor: compare each DUT event with the head of its expectation queue.
  initial begin
    mem_ev_t m;
    rf_ev_t r;
    done_ev_t dn;
    logic [31:0] pv;
    forever begin
      @(negedge sys_clk);
      if (!in_reset) begin
        if (mem_req) begin
          if (exp_mem_q.size() == 0) chk("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
          else begin
            m = exp_mem_q[0];
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            chk("rf_ra", {28'd0, rf_ra}, {28'd0, m.idx});
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            if (mem_ack || mem_abort) void'(exp_mem_q.pop_front());
          end
        end
        if (rf_we) begin
          if (exp_rf_q.size() == 0) chk("rf_we_unexpected", {28'd0, rf_wa}, 32'hFFFF_FFFF);
          else begin
            r = exp_rf_q.pop_front();
            chk("rf_wa", {28'd0, rf_wa}, {28'd0, r.wa});
            chk("rf_wd", rf_wd, r.wd);
          end
          rf[rf_wa] = rf_wd;
        end
        if (pc_we) begin
          if (exp_pc_q.size() == 0) chk("pc_we_unexpected", {31'd0, pc_we}, 32'd0);
          else begin
            pv = exp_pc_q.pop_front();
            chk("pc_wd", pc_wd, pv);
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
          else begin
            dn = exp_done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(dn.cyc));
            chk("abort_flag", {31'd0, abort_o}, {31'd0, dn.ab});
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    seed_g = $urandom;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    repeat (3) @(negedge sys_clk);
    chk_quiet("reset");
    sys_rst_n = 1'b0; in_reset = 1'b0;

    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd2,  16'h000B, 32'h0000_0100, 0, -1, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  16'h8001, 32'h0000_0200, 0, -1, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  16'h0010, 32'h0000_0300, 0, -1, 1'b0);
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  16'h0000, 32'h0000_0400, 0, -1, 1'b0);
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd6,  16'h0F0F, 32'h0000_0500, 3, -1, 1'b1);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'h00F0, 32'h0000_1000, 1, -1, 1'b0);
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  16'h7000, 32'hFFFF_FFF8, 0, -1, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  16'hFFFF, 32'h0000_0020, 0, -1, 1'b0);
`ifdef LDM_STM_ABORT_EN
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  16'h0E06, 32'h0000_0600, 1, 1, 1'b0);
`endif

    // Reset in the middle of a slow store sequence.
    @(negedge sys_clk);
    ack_dly = 3; abort_at = -1;
    rf[1] = 32'h0000_0700;
    model(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'hFFFF, 32'h0000_0700, 3, -1, cyc);
    is_load = 1'b0; pre = 1'b0; up = 1'b1; wback = 1'b1; rn = 4'd1;
    reg_list = 16'hFFFF; base_val = 32'h0000_0700; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (5) @(negedge sys_clk);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1; in_reset = 1'b1;
    #1;
    chk_quiet("midreset");
    exp_mem_q.delete(); exp_rf_q.delete(); exp_pc_q.delete(); exp_done_q.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0; in_reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int t = 0; t < 30; t++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom), $urandom,
             int'($urandom_range(2)), -1, 1'($urandom));
    end

    repeat (2) @(negedge sys_clk);
    chk("exp_mem_left", 32'(exp_mem_q.size()), 32'd0);
    chk("exp_rf_left", 32'(exp_rf_q.size()), 32'd0);
    chk("exp_pc_left", 32'(exp_pc_q.size()), 32'd0);
    chk("exp_done_left", 32'(exp_done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle load/store-multiple engine for the MCU datapath.
- Acts as the initiator toward the register file (read/write ports) and as the initiator toward data memory, walking a 16-bit register list.
- Drives register-file read/write addresses and data in place of the single-cycle decoder while busy, and stalls the core PC until done.

Parameters:
- DATA_W, 32, data and address width.
- ADDR_STEP, 4, byte increment per transferred word.

Ports:
- sys_clk  input  1  clock, rising-edge sequencing (register file writes on falling edge).
- sys_rst_n  input  1  reset: reset sys_rst_n, asynchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- is_load  input  1  1 = LDM, 0 = STM.
- pre  input  1  P bit: 1 = before, 0 = after.
- up  input  1  U bit: 1 = increment, 0 = decrement.
- wback  input  1  W bit: write updated base to rn.
- rn  input  4  base register index.
- reg_list  input  16  bit i = transfer Ri.
- base_val  input  DATA_W  current value of rn.
- rf_ra  output  4  register-file read address (STM source).
- rf_rd  input  DATA_W  register-file read data (combinational).
- rf_wa  output  4  register-file write address.
- rf_we  output  1  register-file write enable.
- rf_wd  output  DATA_W  register-file write data.
- pc_we  output  1  load targets R15; pc_wd valid.
- pc_wd  output  DATA_W  loaded PC value.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = store.
- mem_addr  output  DATA_W  word address.
- mem_wdata  output  DATA_W  store data.
- mem_rdata  input  DATA_W  load data, valid with mem_ack.
- mem_ack  input  1  transfer complete this cycle.
- busy  output  1  high from the cycle after accepted start through DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal list, address and base registers cleared. Reset mid-operation aborts immediately, with no further rf or mem activity.
- n = popcount(reg_list), 5-bit.
- Start address, latched at start:
  - IA: base.
  - IB: base + 4.
  - DA: base − 4n + 4.
  - DB: base − 4n.
- New base: base + 4n if up, else base − 4n. Arithmetic is modulo 2^32.
- Registers transfer lowest index first at ascending addresses.
- States:
  - IDLE: start=1 latches inputs. If reg_list=0, go to DONE (no transfer, no writeback). Otherwise go to XFER.
  - XFER: cur = lowest set bit of remaining list. mem_req=1, mem_addr=addr, mem_we=!is_load, rf_ra=cur, mem_wdata=rf_rd. Signals stay stable until mem_ack.
  - On mem_ack in XFER:
    - Load with cur≠15: rf_we=1, rf_wa=cur, rf_wd=mem_rdata in the same cycle.
    - Load with cur=15: pc_we=1, pc_wd=mem_rdata; rf_we stays 0.
    - Then clear bit cur and add 4 to addr. If the list is now empty, go to WB; otherwise stay in XFER with mem_req held high.
  - WB: if wback and not (is_load and reg_list[rn]), rf_we=1, rf_wa=rn, rf_wd=new base. Go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Minimum latency: n + 2 cycles from the cycle after start to done.
- start while busy is ignored.
- The store sequence reads rn's original value from the register file because writeback happens only in WB.
- rn=15 with wback: writeback is suppressed.
- mem_ack outside XFER is ignored.

Optional Feature:
- Macro: LDM_STM_ABORT_EN. Adds input mem_abort (1 bit) and output abort (1 bit, reset 0).
- With the macro, mem_abort in XFER:
  - Takes priority over mem_ack.
  - Suppresses that cycle's rf_we/pc_we.
  - Skips WB and goes to DONE with abort=1 alongside done.
  - Registers already loaded keep their values.
- Without the macro: no port and no logic; memory is assumed never to fault.

Decomposition:
- Shared package holds:
  - State enum: IDLE, XFER, WB, DONE.
  - Constants: REG_PC=4'd15, ADDR_STEP.
  - Function popcount16.
- Natural sub-module: lowest_set_bit16, a combinational 16→4 priority encoder with valid flag, reused by the decoder.

Test Plan:
- STM IA, base=0x100, list=0x000B (R0,R1,R3), ack every cycle:
  - Writes land at 0x100, 0x104, 0x108 with rf_ra = 0, 1, 3.
  - With W=1, rn=2 receives 0x10C; done arrives 5 cycles after start.
- LDM DB, base=0x200, list=0x8001 (R0, R15):
  - Reads from 0x1F8 → R0 and 0x1FC → pc_we.
  - rf_we is never asserted with wa=15.
- LDM IA, rn=4, list=0x0010, W=1: R4 gets the loaded value and WB writes nothing.
- Empty list with start: done one cycle after IDLE, no mem_req, no rf_we.
- mem_ack delayed 3 cycles per word: mem_addr and mem_wdata stay stable while mem_req is held; start pulses during busy are ignored.
- Reset asserted mid-XFER: all outputs 0 immediately and the state returns to IDLE. With LDM_STM_ABORT_EN, mem_abort on the second word gives abort=1 with done, and no WB write.
